// File: rtl/uart2bus_pkg.sv
// Shared types and defaults for the uart2bus internal bus fabric.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart2bus_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 8;
    localparam int MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Index width for a vector of n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; valid is low when no request bit is set.
//   req    : request vector, one bit per requester
//   ptr    : highest-priority index for this pick
//   winner : chosen index (0 when valid is low)
//   valid  : at least one request present
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    // One extra bit so ptr + offset cannot overflow before the wrap subtract.
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(N)) begin
                sum = sum - SUM_W'(N);
            end
            if (!valid && req[sum[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart2bus_bus_arbiter.sv
// Round-robin arbiter sharing the internal bus between N masters, with hold limit and no-grant strobe flag.
// Latency: gnt one cycle after req seen in IDLE; release takes one cycle, then two gnt-free cycles before the next owner.
// Backpressure: masters wait on m_gnt; an owner holding past MAX_HOLD while others wait is forced off and must re-request.
//   m_req/m_gnt                : per-master request and registered one-hot grant
//   m_address/m_wr_data        : packed per-master address and write data, master i at [i*W +: W]
//   m_write/m_read             : per-master strobes, forwarded only for the owner
//   bus_*                      : shared slave bus, zero when nobody owns it
//   m_rd_data                  : slave read data broadcast to every master
//   err_no_gnt/err_clr         : sticky flag for strobes without a grant, and its clear
module uart2bus_bus_arbiter
    import uart2bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_HOLD  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_MASTERS-1:0]            m_req,
    output logic [N_MASTERS-1:0]            m_gnt,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_address,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wr_data,
    input  logic [N_MASTERS-1:0]            m_write,
    input  logic [N_MASTERS-1:0]            m_read,
    output logic [DATA_W-1:0]               m_rd_data,
    output logic [ADDR_W-1:0]               bus_address,
    output logic [DATA_W-1:0]               bus_wr_data,
    output logic                            bus_write,
    output logic                            bus_read,
    input  logic [DATA_W-1:0]               bus_rd_data,
    output logic                            err_no_gnt,
    input  logic                            err_clr
);

    localparam int IDX_W    = idx_width(N_MASTERS);
    localparam int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    arb_state_t         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [IDX_W-1:0]   next_ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               gnt_any;
    logic               others_req;
    logic               hold_expired;
    logic               release_now;
    logic               strobe_no_gnt;

    rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (m_req),
        .ptr    (rr_ptr),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    // Only meaningful in GRANT, where m_gnt is exactly the owner bit.
    assign others_req   = |(m_req & ~m_gnt);
    // Covers both the exact limit and the saturated case, so a late
    // competitor still triggers release on its first cycle.
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt >= HOLD_W'(HOLD_LIM));
    assign release_now  = !m_req[owner] || (hold_expired && others_req);
    assign next_ptr     = (owner == IDX_W'(N_MASTERS - 1)) ? '0 : owner + 1'b1;

    assign strobe_no_gnt = |((m_write | m_read) & ~m_gnt);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            m_gnt      <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            err_no_gnt <= 1'b0;
        end else begin
            // A new violation outranks a clear in the same cycle.
            err_no_gnt <= strobe_no_gnt | (err_no_gnt & ~err_clr);
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= GRANT;
                        owner    <= pick_idx;
                        m_gnt    <= N_MASTERS'(1) << pick_idx;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (release_now) begin
                        m_gnt  <= '0;
                        rr_ptr <= next_ptr;
                        state  <= TURN;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gating by reset blanks the bus in the very cycle reset is applied,
    // so an owner's in-flight strobe never reaches a slave during reset.
    assign gnt_any = reset & (|m_gnt);

    always_comb begin
        bus_address = '0;
        bus_wr_data = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_any && owner == IDX_W'(i)) begin
                bus_address = m_address[i*ADDR_W +: ADDR_W];
                bus_wr_data = m_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read and write from the owner pass through together; the slave
    // decides what to do with a simultaneous pair.
    assign bus_write = gnt_any & m_write[owner];
    assign bus_read  = gnt_any & m_read[owner];
    assign m_rd_data = bus_rd_data;

endmodule
